// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller and its queue.
package instr_fetch_ctrl_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_ctrl_fetch_queue.sv
// Circular fetch queue: push at tail, pop at head, flush empties it in one edge.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        pop_ok  = pop && (count != '0);
        push_ok = push && ((count != CNT_FULL) || pop_ok);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; emptiness is tracked by count alone, so stale words are never observed.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns pc and the fetch FSM, feeds decode through fetch_queue.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 64,
    parameter int          QDEPTH     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [31:0]         imem_addr,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    input  logic                id_ready,
    output logic                id_valid,
    output logic [INSTR_W-1:0]  id_instr,
    output logic [31:0]         id_pc,
    output logic                halted,
    output logic                align_err,
    output logic [15:0]         fetch_count
);

    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);
    localparam logic [32:0]      PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_FETCH = ST_FETCH;
    localparam logic [1:0] S_FULL  = ST_FULL;
    localparam logic [1:0] S_HALT  = ST_HALT;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [31:0]      pc;
    logic [31:0]      pc_nxt;
    logic [CNT_W-1:0] q_count;
    logic [CNT_W-1:0] cnt_after;
    logic             pop;
    logic             push;
    logic             flush;
    logic             room;
    logic             at_end;
    fetch_entry_t     head;
    fetch_entry_t     tail_entry;

    always_comb begin
        pop        = (q_count != '0) && id_ready;
        flush      = redirect_valid && (state != S_IDLE);
        at_end     = {1'b0, pc} >= PC_LIMIT;
        room       = (q_count < CNT_FULL) || ((q_count == CNT_FULL) && pop);
        push       = (state == S_FETCH) && !flush && !at_end && room;
        cnt_after  = q_count + CNT_W'(push) - CNT_W'(pop);
        tail_entry = '{pc: pc, instr: imem_rdata};
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_data (tail_entry),
        .pop       (pop && !flush),
        .head_data (head),
        .count     (q_count)
    );

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: begin
                if (at_end) begin
                    state_nxt = S_HALT;
                end else begin
                    if (push) pc_nxt = pc + 32'd4;
                    if ((cnt_after == CNT_FULL) && !pop) state_nxt = S_FULL;
                end
            end
            S_FULL:  if (pop) state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
        // A taken branch overrides everything outside IDLE; low address bits are dropped.
        if (flush) begin
            state_nxt = S_FETCH;
            pc_nxt    = {redirect_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            align_err   <= 1'b0;
            fetch_count <= 16'h0000;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (flush && (redirect_pc[1:0] != 2'b00)) align_err <= 1'b1;
            if (push && (fetch_count != 16'hFFFF)) fetch_count <= fetch_count + 16'd1;
        end
    end

    assign imem_addr = pc;
    assign id_valid  = (q_count != '0);
    assign id_instr  = id_valid ? head.instr : NOP;
    assign id_pc     = id_valid ? head.pc : 32'h0;
    assign halted    = (state == S_HALT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl against a queue-based behavioural model.
module tb_instr_fetch_ctrl;

    localparam int QDEPTH     = 2;
    localparam int IMEM_WORDS = 64;
    localparam int LIMIT      = IMEM_WORDS * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        halted;
    logic        align_err;
    logic [15:0] fetch_count;

    logic [31:0] mem [IMEM_WORDS];

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: queued entries plus a few flags describing fetch progress.
    logic [63:0] mq[$];
    int unsigned m_pc;
    int unsigned m_cnt;
    bit          m_started;
    bit          m_halt;
    bit          m_stall;
    bit          m_align;

    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr < 32'(LIMIT)) ? mem[imem_addr[7:2]] : 32'h0;

    instr_fetch_ctrl #(
        .RESET_PC   (32'h0),
        .IMEM_WORDS (IMEM_WORDS),
        .QDEPTH     (QDEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .halted         (halted),
        .align_err      (align_err),
        .fetch_count    (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc      = 0;
        m_cnt     = 0;
        m_started = 0;
        m_halt    = 0;
        m_stall   = 0;
        m_align   = 0;
    endtask

    function automatic logic [31:0] mem_word(input int unsigned a);
        return (a < LIMIT) ? mem[a / 4] : 32'h0;
    endfunction

    // One rising edge of the reference behaviour, using the inputs held across that edge.
    task automatic model_edge();
        bit do_pop;
        bit can_push;
        if (!m_started) begin
            m_started = 1;
            return;
        end
        if (redirect_valid) begin
            mq.delete();
            m_pc    = {redirect_pc[31:2], 2'b00};
            m_align = m_align || (redirect_pc[1:0] != 2'b00);
            m_halt  = 0;
            m_stall = 0;
            return;
        end
        do_pop = (mq.size() != 0) && id_ready;
        if (m_halt || m_stall) begin
            if (do_pop) begin
                void'(mq.pop_front());
                m_stall = 0;
            end
            return;
        end
        if (m_pc >= LIMIT) begin
            m_halt = 1;
            if (do_pop) void'(mq.pop_front());
            return;
        end
        can_push = (mq.size() < QDEPTH) || do_pop;
        if (do_pop) void'(mq.pop_front());
        if (can_push) begin
            mq.push_back({m_pc, mem_word(m_pc)});
            m_pc += 4;
            if (m_cnt < 16'hFFFF) m_cnt++;
        end
        if (mq.size() == QDEPTH && !do_pop) m_stall = 1;
    endtask

    task automatic compare_all();
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [63:0] head;
        e_pc    = 32'h0;
        e_instr = 32'h0;
        if (mq.size() != 0) begin
            head    = mq[0];
            e_pc    = head[63:32];
            e_instr = head[31:0];
        end
        check("id_valid",    id_valid,    mq.size() != 0);
        check("id_pc",       id_pc,       e_pc);
        check("id_instr",    id_instr,    e_instr);
        check("imem_addr",   imem_addr,   m_pc);
        check("halted",      halted,      m_halt);
        check("align_err",   align_err,   m_align);
        check("fetch_count", fetch_count, m_cnt);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_id_valid",    id_valid,    32'h0);
        check("rst_id_pc",       id_pc,       32'h0);
        check("rst_id_instr",    id_instr,    32'h0);
        check("rst_imem_addr",   imem_addr,   32'h0);
        check("rst_halted",      halted,      32'h0);
        check("rst_align_err",   align_err,   32'h0);
        check("rst_fetch_count", fetch_count, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) mem[i] = $urandom;
        mem[0]  = 32'h2008_0020;
        mem[1]  = 32'h2009_0037;
        mem[14] = 32'h0800_000E;

        // Basic streaming with decode always ready.
        id_ready = 1'b1;
        do_reset();
        step();
        check("first_edge_empty", id_valid, 32'h0);
        step();
        check("stream_instr0", id_instr, 32'h2008_0020);
        check("stream_pc0",    id_pc,    32'h0);
        step();
        check("stream_instr1", id_instr, 32'h2009_0037);
        check("stream_pc1",    id_pc,    32'h4);
        for (int i = 0; i < 4; i++) step();

        // Back-pressure: queue fills at two entries, pc holds at 8.
        id_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) step();
        check("stall_pc_hold", imem_addr, 32'h8);
        check("stall_head_pc", id_pc,     32'h0);
        id_ready = 1'b1;
        step();
        check("drain_pc_a", id_pc, 32'h4);
        step();
        check("drain_pc_b", id_pc, 32'h8);
        step();

        // Redirect into a full queue.
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h38;
        step();
        check("redir_flush", id_valid, 32'h0);
        redirect_valid = 1'b0;
        step();
        check("redir_pc",    id_pc,    32'h38);
        check("redir_instr", id_instr, 32'h0800_000E);

        // Random traffic with occasional, sometimes misaligned, redirects.
        for (int i = 0; i < 400; i++) begin
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 32'($urandom_range(0, 70) * 4);
            if ($urandom_range(0, 7) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
            step();
        end
        redirect_valid = 1'b0;

        // Run off the end of memory, then restart with a redirect.
        id_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 200 && !halted; i++) step();
        check("halt_reached",  halted,      32'h1);
        check("halt_count",    fetch_count, 32'd64);
        check("halt_pc",       imem_addr,   32'd256);
        for (int i = 0; i < 4; i++) step();
        check("halt_no_push",  fetch_count, 32'd64);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        check("unhalt", halted, 32'h0);
        step();
        check("resume_pc", id_pc, 32'h0);

        // Misaligned redirect sets a sticky flag.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        step();
        redirect_valid = 1'b0;
        check("align_set", align_err, 32'h1);
        step();
        check("align_pc", id_pc, 32'h40);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        step();
        redirect_valid = 1'b0;
        step();
        check("align_sticky", align_err, 32'h1);

        // Asynchronous reset with two entries queued.
        id_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) step();
        check("pre_async_valid", id_valid, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_id_valid",    id_valid,    32'h0);
        check("async_fetch_count", fetch_count, 32'h0);
        check("async_align_err",   align_err,   32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        step();
        check("post_async_pc", id_pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
